// File: rtl/ldst_unit.sv
// ldst_unit: memory stage between the execute stage and the data-memory port.
// Accepts one load/store at a time, drives a word-aligned bus access with byte
// enables and lane-replicated store data, waits out waitrequest, then returns
// a single (sign/zero-extended) writeback response or a one-cycle fault pulse.
module ldst_unit #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    // request from execute stage
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_is_store,
    input  logic [2:0]    i_req_funct3,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wrdata,
    input  logic [4:0]    i_req_rd,
    // writeback response
    output logic          o_resp_valid,
    output logic          o_resp_wb,
    output logic [4:0]    o_resp_rd,
    output logic [DW-1:0] o_resp_data,
    output logic          o_fault,
    // data-memory bus
    output logic [AW-1:0] o_ldst_addr,
    output logic          o_ldst_rd,
    output logic          o_ldst_wr,
    output logic [DW-1:0] o_ldst_wrdata,
    output logic [3:0]    o_ldst_byte_en,
    input  logic [DW-1:0] i_ldst_rddata,
    input  logic          i_ldst_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_RDATA,
        S_RESP,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    // latched request (only meaningful while a request is in flight)
    logic          is_store_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wrdata_q;
    logic [3:0]    be_q;
    logic [4:0]    rd_q;

    // response registers, held between responses
    logic [DW-1:0] resp_data_q;
    logic [4:0]    resp_rd_q;

    logic accept;
    logic access_done;

    // funct3 encodings legal for the request type
    function automatic logic req_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
        end
        return ok;
    endfunction

    // natural alignment: halves on even bytes, words on 4-byte boundaries
    function automatic logic req_aligned(input logic [2:0] f3, input logic [1:0] a);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = (a[0] == 1'b0);
            2'b10:   ok = (a == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // active byte lanes for the access size and byte offset
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // replicate store data across lanes so the enabled lanes carry it
    function automatic logic [DW-1:0] store_data(input logic [2:0] f3, input logic [DW-1:0] d);
        logic [DW-1:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // pick the addressed lane out of the bus word and extend it
    function automatic logic [DW-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [DW-1:0] rdata);
        logic [DW-1:0] lane;
        logic [DW-1:0] r;
        lane = rdata >> {a, 3'b000};
        case (f3)
            3'b000:  r = {{(DW-8){lane[7]}}, lane[7:0]};
            3'b001:  r = {{(DW-16){lane[15]}}, lane[15:0]};
            3'b100:  r = {{(DW-8){1'b0}}, lane[7:0]};
            3'b101:  r = {{(DW-16){1'b0}}, lane[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign accept      = i_req_valid && (state_q == S_IDLE);
    assign access_done = (state_q == S_ACCESS) && !i_ldst_waitrequest;

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (req_legal(i_req_is_store, i_req_funct3) &&
                        req_aligned(i_req_funct3, i_req_addr[1:0])) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_ACCESS: begin
                if (!i_ldst_waitrequest) begin
                    state_d = is_store_q ? S_RESP : S_RDATA;
                end
            end
            S_RDATA: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // latch the request on acceptance; bus fields stay frozen through any stall
    always_ff @(posedge clk) begin
        if (accept) begin
            is_store_q <= i_req_is_store;
            funct3_q   <= i_req_funct3;
            addr_q     <= i_req_addr;
            wrdata_q   <= store_data(i_req_funct3, i_req_wrdata);
            be_q       <= byte_enable(i_req_funct3, i_req_addr[1:0]);
            rd_q       <= i_req_rd;
        end
    end

    // response registers change only on entry to RESP; stores report rd=0/data=0
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data_q <= '0;
            resp_rd_q   <= '0;
        end else if (state_q == S_RDATA) begin
            resp_data_q <= load_extend(funct3_q, addr_q[1:0], i_ldst_rddata);
            resp_rd_q   <= rd_q;
        end else if (access_done && is_store_q) begin
            resp_data_q <= '0;
            resp_rd_q   <= '0;
        end
    end

    // outputs decoded from state; bus fields are zero outside ACCESS
    always_comb begin
        o_req_ready    = 1'b0;
        o_resp_valid   = 1'b0;
        o_resp_wb      = 1'b0;
        o_fault        = 1'b0;
        o_ldst_rd      = 1'b0;
        o_ldst_wr      = 1'b0;
        o_ldst_addr    = '0;
        o_ldst_wrdata  = '0;
        o_ldst_byte_en = 4'b0000;
        case (state_q)
            S_IDLE: o_req_ready = 1'b1;
            S_ACCESS: begin
                o_ldst_rd      = !is_store_q;
                o_ldst_wr      = is_store_q;
                o_ldst_addr    = {addr_q[AW-1:2], 2'b00};
                o_ldst_byte_en = be_q;
                o_ldst_wrdata  = is_store_q ? wrdata_q : '0;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_wb    = !is_store_q && (rd_q != 5'd0);
            end
            S_FAULT: o_fault = 1'b1;
            default: ;
        endcase
    end

    assign o_resp_data = resp_data_q;
    assign o_resp_rd   = resp_rd_q;

endmodule

// File: tb/tb_ldst_unit.sv
// Bench for ldst_unit: directed vector table, reset-abort sequence, and
// randomized requests checked against an arithmetic reference model.
module tb_ldst_unit;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_is_store;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wrdata;
    logic [4:0]  i_req_rd;
    logic        o_resp_valid;
    logic        o_resp_wb;
    logic [4:0]  o_resp_rd;
    logic [31:0] o_resp_data;
    logic        o_fault;
    logic [31:0] o_ldst_addr;
    logic        o_ldst_rd;
    logic        o_ldst_wr;
    logic [31:0] o_ldst_wrdata;
    logic [3:0]  o_ldst_byte_en;
    logic [31:0] i_ldst_rddata;
    logic        i_ldst_waitrequest;

    ldst_unit #(.AW(32), .DW(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_is_store     (i_req_is_store),
        .i_req_funct3       (i_req_funct3),
        .i_req_addr         (i_req_addr),
        .i_req_wrdata       (i_req_wrdata),
        .i_req_rd           (i_req_rd),
        .o_resp_valid       (o_resp_valid),
        .o_resp_wb          (o_resp_wb),
        .o_resp_rd          (o_resp_rd),
        .o_resp_data        (o_resp_data),
        .o_fault            (o_fault),
        .o_ldst_addr        (o_ldst_addr),
        .o_ldst_rd          (o_ldst_rd),
        .o_ldst_wr          (o_ldst_wr),
        .o_ldst_wrdata      (o_ldst_wrdata),
        .o_ldst_byte_en     (o_ldst_byte_en),
        .i_ldst_rddata      (i_ldst_rddata),
        .i_ldst_waitrequest (i_ldst_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdd;
        logic [4:0]  rd;
        int          nwait;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] edata;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_data = 32'h0;
    logic [4:0]  last_rd   = 5'd0;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rdd, input logic [4:0] rd, input int nwait,
                                input logic fault, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] edata);
        vec_t v;
        v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdd = rdd;
        v.rd = rd; v.nwait = nwait; v.fault = fault; v.be = be; v.ewd = ewd; v.edata = edata;
        return v;
    endfunction

    // Reference model: sizes in bytes, byte-lane arithmetic, two's-complement extension.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rdd,
                                  output logic flt, output logic [3:0] be,
                                  output logic [31:0] ewd, output logic [31:0] edata);
        int          size;
        int          off;
        logic        legal;
        logic [63:0] v;
        logic [63:0] mask;
        size  = 1 << f3[1:0];
        off   = int'(a[1:0]);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        flt   = !legal || ((int'(a) % size) != 0);
        be    = 4'b0000;
        ewd   = 32'h0;
        edata = 32'h0;
        if (!flt) begin
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + size) be[i] = 1'b1;
            if (st) begin
                for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % size) +: 8];
            end else begin
                mask = (64'd1 << (8 * size)) - 64'd1;
                v = ({32'h0, rdd} >> (8 * off)) & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
                edata = v[31:0];
            end
        end
    endfunction

    // Drive one request and check every cycle of its fixed schedule.
    task automatic run_vec(input vec_t v);
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        @(negedge clk);
        chk({v.name, " ready"}, 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1; i_req_is_store = v.st; i_req_funct3 = v.f3;
        i_req_addr = v.addr; i_req_wrdata = v.wd; i_req_rd = v.rd;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0; i_req_is_store = 1'($urandom); i_req_funct3 = 3'($urandom);
        i_req_addr = $urandom; i_req_wrdata = $urandom; i_req_rd = 5'($urandom);
        if (v.fault) begin
            @(negedge clk);
            chk({v.name, " fault"}, 32'(o_fault), 32'd1);
            chk({v.name, " no strobe"}, {30'd0, o_ldst_rd, o_ldst_wr}, 32'd0);
            chk({v.name, " no resp"}, 32'(o_resp_valid), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({v.name, " fault end"}, {30'd0, o_fault, o_resp_valid}, 32'd0);
            chk({v.name, " ready after fault"}, 32'(o_req_ready), 32'd1);
            chk({v.name, " data held"}, o_resp_data, last_data);
            return;
        end
        for (int w = 0; w <= v.nwait; w++) begin
            i_ldst_waitrequest = (w < v.nwait);
            @(negedge clk);
            chk({v.name, " strobes"}, {30'd0, o_ldst_rd, o_ldst_wr}, {30'd0, !v.st, v.st});
            chk({v.name, " addr"}, o_ldst_addr, exp_addr);
            chk({v.name, " be"}, 32'(o_ldst_byte_en), 32'(v.be));
            if (v.st) chk({v.name, " wrdata"}, o_ldst_wrdata, v.ewd);
            chk({v.name, " busy"}, {30'd0, o_req_ready, o_resp_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        i_ldst_waitrequest = 1'b0;
        if (!v.st) begin
            i_ldst_rddata = v.rdd;
            @(negedge clk);
            chk({v.name, " rdata idle"}, {29'd0, o_ldst_rd, o_ldst_wr, o_resp_valid}, 32'd0);
            @(posedge clk);
            #1;
            i_ldst_rddata = $urandom;
        end
        @(negedge clk);
        chk({v.name, " resp_valid"}, 32'(o_resp_valid), 32'd1);
        chk({v.name, " wb"}, 32'(o_resp_wb), 32'(!v.st && v.rd != 5'd0));
        chk({v.name, " resp_rd"}, 32'(o_resp_rd), v.st ? 32'd0 : 32'(v.rd));
        chk({v.name, " resp_data"}, o_resp_data, v.st ? 32'd0 : v.edata);
        last_data = v.st ? 32'd0 : v.edata;
        last_rd   = v.st ? 5'd0 : v.rd;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({v.name, " pulse end"}, {30'd0, o_resp_valid, o_resp_wb}, 32'd0);
        chk({v.name, " idle ready"}, 32'(o_req_ready), 32'd1);
        chk({v.name, " data held"}, o_resp_data, last_data);
        chk({v.name, " rd held"}, 32'(o_resp_rd), 32'(last_rd));
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; i_req_valid = 1'b0; i_req_is_store = 1'b0; i_req_funct3 = 3'd0;
        i_req_addr = 32'h0; i_req_wrdata = 32'h0; i_req_rd = 5'd0;
        i_ldst_rddata = 32'h0; i_ldst_waitrequest = 1'b0;

        //            name        st f3     addr      wd            rdd           rd nw flt be       ewd           edata
        vecs.push_back(mk("SW",   1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        7, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("LB",   0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 3, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80));
        vecs.push_back(mk("LBU",  0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 3, 0, 0, 4'b1000, 32'h0,        32'h00000080));
        vecs.push_back(mk("SHw",  1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        0, 3, 0, 4'b1100, 32'hABCDABCD, 32'h0));
        vecs.push_back(mk("LWmis",0, 3'b010, 32'h101, 32'h0,        32'h0,        4, 0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk("LHx0", 0, 3'b001, 32'h200, 32'h0,        32'h0000F00D, 0, 0, 0, 4'b0011, 32'h0,        32'hFFFFF00D));
        vecs.push_back(mk("LHx5", 0, 3'b001, 32'h200, 32'h0,        32'h0000F00D, 5, 0, 0, 4'b0011, 32'h0,        32'hFFFFF00D));
        vecs.push_back(mk("SB",   1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        1, 0, 0, 4'b0010, 32'hABABABAB, 32'h0));
        vecs.push_back(mk("LHU",  0, 3'b101, 32'h102, 32'h0,        32'h80011234, 9, 2, 0, 4'b1100, 32'h0,        32'h00008001));
        vecs.push_back(mk("LW",   0, 3'b010, 32'h104, 32'h0,        32'h12345678, 31,1, 0, 4'b1111, 32'h0,        32'h12345678));
        vecs.push_back(mk("Sill", 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk("Lill", 0, 3'b011, 32'h100, 32'h0,        32'h0,        2, 0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk("SWmis",1, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk("LHmis",0, 3'b001, 32'h201, 32'h0,        32'h0,        6, 0, 1, 4'b0000, 32'h0,        32'h0));
        vecs.push_back(mk("LBpos",0, 3'b000, 32'h102, 32'h0,        32'h007F0000, 8, 0, 0, 4'b0100, 32'h0,        32'h0000007F));

        // reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset ready", 32'(o_req_ready), 32'd1);
        chk("reset strobes", {28'd0, o_ldst_rd, o_ldst_wr, o_resp_valid, o_fault}, 32'd0);
        chk("reset resp", {o_resp_data[26:0], o_resp_rd}, 32'd0);
        chk("reset bus", o_ldst_addr | o_ldst_wrdata | 32'(o_ldst_byte_en), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while a load is stalled in ACCESS
        @(negedge clk);
        i_req_valid = 1'b1; i_req_is_store = 1'b0; i_req_funct3 = 3'b010;
        i_req_addr = 32'h40; i_req_rd = 5'd4; i_ldst_waitrequest = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(negedge clk);
        chk("abort stalled rd", 32'(o_ldst_rd), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort still stalled", 32'(o_ldst_rd), 32'd1);
        @(posedge clk);
        #1 begin reset = 1'b0; i_ldst_waitrequest = 1'b0; end
        @(negedge clk);
        chk("abort rd drop", 32'(o_ldst_rd), 32'd0);
        chk("abort ready", 32'(o_req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk("abort no resp", {30'd0, o_resp_valid, o_fault}, 32'd0);
            @(negedge clk);
        end
        last_data = 32'h0; last_rd = 5'd0;
        run_vec(mk("LWafter", 0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 12, 0, 0, 4'b1111, 32'h0, 32'hCAFEF00D));

        // randomized requests against the reference model
        for (int n = 0; n < 150; n++) begin
            v.name  = "rand";
            v.st    = 1'($urandom);
            v.f3    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (v.st ? 3'b000 : {1'($urandom), 2'b00});
            v.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = ($urandom_range(0, 1) == 0) ? 2'b00 : {1'($urandom), 1'b0};
            v.wd    = $urandom;
            v.rdd   = $urandom;
            v.rd    = 5'($urandom);
            v.nwait = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            model(v.st, v.f3, v.addr, v.wd, v.rdd, v.fault, v.be, v.ewd, v.edata);
            run_vec(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
